// File: rtl/i2s_tx_stereo.sv
// Stereo I2S master: one-entry valid/ready holding register, atomic L/R frame load, underrun strobe.
// Build option: define I2S_UNDERRUN_MUTE_EN to output silence on underrun instead of repeating the last pair.
module i2s_tx_stereo #(
   parameter int SMP_W   = 16,
   parameter int SLOT_W  = 32,
   parameter int BCK_DIV = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [SMP_W-1:0] SMP_L,
   input  logic [SMP_W-1:0] SMP_R,
   input  logic             SMP_VALID,
   output logic             SMP_READY,
   output logic             SCK,
   output logic             BCK,
   output logic             LCK,
   output logic             DIN,
   output logic             FRAME,
   output logic             UNDERRUN
);
   localparam int DW = $clog2(BCK_DIV);
   localparam int BW = $clog2(2 * SLOT_W);

   localparam logic [DW-1:0]    DIV_LAST = DW'(BCK_DIV - 1);
   localparam logic [DW-1:0]    DIV_HALF = DW'(BCK_DIV / 2);
   localparam logic [BW-1:0]    B_ZERO   = {BW{1'b0}};
   localparam logic [BW-1:0]    B_LAST   = BW'(2 * SLOT_W - 1);
   localparam logic [BW-1:0]    B_SLOT   = BW'(SLOT_W);
   localparam logic [BW-1:0]    B_SMP    = BW'(SMP_W);
   localparam logic [BW-1:0]    B_LCK_LO = BW'(SLOT_W - 1);
   localparam logic [BW-1:0]    B_LCK_HI = BW'(2 * SLOT_W - 2);
   localparam logic [SMP_W-1:0] SMP_ZERO = {SMP_W{1'b0}};

   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [BW-1:0]    b_q, b_d;
   logic             bck_q, bck_d, lck_q, lck_d, din_q, din_d;
   logic             frame_q, frame_d, underrun_q, underrun_d;
   logic             ready_q, ready_d, hold_full_q, hold_full_d;
   logic [SMP_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SMP_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic [SMP_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
   logic             fall_s, accept_s;

   // Next-state logic: BCK divider, slot index, serialiser and holding register.
   always_comb begin
      div_cnt_d   = (div_cnt_q == DIV_LAST) ? {DW{1'b0}} : div_cnt_q + 1'b1;
      fall_s      = (div_cnt_q == DIV_LAST);
      bck_d       = (div_cnt_d >= DIV_HALF);
      accept_s    = SMP_VALID && ready_q;
      b_d         = b_q;
      lck_d       = lck_q;
      din_d       = din_q;
      frame_d     = 1'b0;
      underrun_d  = 1'b0;
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      last_l_d    = last_l_q;
      last_r_d    = last_r_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;

      if (fall_s) begin
         b_d   = (b_q == B_LAST) ? B_ZERO : b_q + 1'b1;
         lck_d = (b_d >= B_LCK_LO) && (b_d <= B_LCK_HI);
         if (b_d == B_ZERO) begin
            frame_d = 1'b1;
            if (hold_full_q) begin
               shift_l_d   = hold_l_q;
               shift_r_d   = hold_r_q;
               last_l_d    = hold_l_q;
               last_r_d    = hold_r_q;
               hold_full_d = 1'b0;
            end else begin
               underrun_d = 1'b1;
`ifdef I2S_UNDERRUN_MUTE_EN
               shift_l_d  = SMP_ZERO;
               shift_r_d  = SMP_ZERO;
               last_l_d   = SMP_ZERO;
               last_r_d   = SMP_ZERO;
`else
               shift_l_d  = last_l_q;
               shift_r_d  = last_r_q;
`endif
            end
            din_d = shift_l_d[SMP_W-1];
         end else if (b_d < B_SMP) begin
            shift_l_d = shift_l_q << 1'b1;
            din_d     = shift_l_d[SMP_W-1];
         end else if (b_d == B_SLOT) begin
            din_d = shift_r_q[SMP_W-1];
         end else if ((b_d > B_SLOT) && ((b_d - B_SLOT) < B_SMP)) begin
            shift_r_d = shift_r_q << 1'b1;
            din_d     = shift_r_d[SMP_W-1];
         end else begin
            din_d = 1'b0;
         end
      end else begin
         b_d = b_q;
      end

      // An accept coinciding with an empty-holding frame load lands after the load decision.
      if (accept_s) begin
         hold_l_d    = SMP_L;
         hold_r_d    = SMP_R;
         hold_full_d = 1'b1;
      end else begin
         hold_l_d = hold_l_q;
      end
      ready_d = ~hold_full_d;
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_q   <= {DW{1'b0}};
         b_q         <= B_LAST;
         bck_q       <= 1'b0;
         lck_q       <= 1'b0;
         din_q       <= 1'b0;
         frame_q     <= 1'b0;
         underrun_q  <= 1'b0;
         ready_q     <= 1'b1;
         hold_full_q <= 1'b0;
         hold_l_q    <= SMP_ZERO;
         hold_r_q    <= SMP_ZERO;
         shift_l_q   <= SMP_ZERO;
         shift_r_q   <= SMP_ZERO;
         last_l_q    <= SMP_ZERO;
         last_r_q    <= SMP_ZERO;
      end else begin
         div_cnt_q   <= div_cnt_d;
         b_q         <= b_d;
         bck_q       <= bck_d;
         lck_q       <= lck_d;
         din_q       <= din_d;
         frame_q     <= frame_d;
         underrun_q  <= underrun_d;
         ready_q     <= ready_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         last_l_q    <= last_l_d;
         last_r_q    <= last_r_d;
      end
   end

   assign SCK       = CLK;
   assign BCK       = bck_q;
   assign LCK       = lck_q;
   assign DIN       = din_q;
   assign FRAME     = frame_q;
   assign UNDERRUN  = underrun_q;
   assign SMP_READY = ready_q;
endmodule
